// File: rtl/axisv_pkg.sv
// Shared types and raster-timing helpers for the AXIS video output blocks.
package axisv_pkg;

  localparam int CNT_W = 12;

  typedef enum logic [1:0] {
    ST_RESYNC = 2'd0,
    ST_ARMED  = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  typedef struct packed {
    logic [CNT_W-1:0] total;
    logic [CNT_W-1:0] sync_start;
    logic [CNT_W-1:0] sync_end;
  } axis_timing_t;

  // Region order on each axis: active, front porch, sync, back porch.
  function automatic axis_timing_t calc_timing(input int pixels, input int front,
                                               input int sync, input int back);
    axis_timing_t t;
    t.sync_start = CNT_W'(pixels + front);
    t.sync_end   = CNT_W'(pixels + front + sync);
    t.total      = CNT_W'(pixels + front + sync + back);
    return t;
  endfunction

endpackage

// File: rtl/axisv_timing_gen.sv
// Free-running raster timing: h/v counters with active, sync and frame-end flags.
module axisv_timing_gen
  import axisv_pkg::*;
#(
  parameter int H_PIXEL_COUNT = 4,
  parameter int V_PIXEL_COUNT = 20,
  parameter int H_FRONT       = 1,
  parameter int H_SYNC        = 2,
  parameter int H_BACK        = 1,
  parameter int V_FRONT       = 1,
  parameter int V_SYNC        = 1,
  parameter int V_BACK        = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [CNT_W-1:0] h_cnt_o,
  output logic [CNT_W-1:0] v_cnt_o,
  output logic             active_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             frame_end_o
);

  localparam axis_timing_t HT = calc_timing(H_PIXEL_COUNT, H_FRONT, H_SYNC, H_BACK);
  localparam axis_timing_t VT = calc_timing(V_PIXEL_COUNT, V_FRONT, V_SYNC, V_BACK);
  localparam logic [CNT_W-1:0] H_LAST = HT.total - CNT_W'(1);
  localparam logic [CNT_W-1:0] V_LAST = VT.total - CNT_W'(1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_PIXEL_COUNT);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_PIXEL_COUNT);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             h_last;
  logic             v_last;

  assign h_last = (h_cnt_q == H_LAST);
  assign v_last = (v_cnt_q == V_LAST);

  always_comb begin
    h_cnt_d = h_last ? '0 : h_cnt_q + CNT_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_last) begin
      v_cnt_d = v_last ? '0 : v_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt_o     = h_cnt_q;
  assign v_cnt_o     = v_cnt_q;
  assign active_o    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hsync_o     = (h_cnt_q >= HT.sync_start) && (h_cnt_q < HT.sync_end);
  assign vsync_o     = (v_cnt_q >= VT.sync_start) && (v_cnt_q < VT.sync_end);
  assign frame_end_o = h_last && v_last;

endmodule

// File: rtl/axisv_lcd_sink.sv
// AXI4-Stream video slave driving a parallel RGB LCD; locks stream framing to the raster.
module axisv_lcd_sink
  import axisv_pkg::*;
#(
  parameter int H_PIXEL_COUNT = 4,
  parameter int V_PIXEL_COUNT = 20,
  parameter int H_FRONT       = 1,
  parameter int H_SYNC        = 2,
  parameter int H_BACK        = 1,
  parameter int V_FRONT       = 1,
  parameter int V_SYNC        = 1,
  parameter int V_BACK        = 1,
  parameter int DATA_WIDTH    = 18
) (
  input  logic                  aclk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [DATA_WIDTH-1:0] lcd_data_o,
  output logic                  lcd_de_o,
  output logic                  lcd_hsync_o,
  output logic                  lcd_vsync_o,
  output logic                  locked_o,
  output logic                  underflow_o,
  output logic                  sync_err_o
);

  // Handshake: a beat transfers on a rising aclk_i edge where tvalid && tready;
  // tready depends only on registered state/counters, never on tvalid.

  localparam logic [CNT_W-1:0] H_LAST_PIX = CNT_W'(H_PIXEL_COUNT - 1);
  localparam logic [CNT_W-1:0] V_LAST_PIX = CNT_W'(V_PIXEL_COUNT - 1);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             active;
  logic             hsync;
  logic             vsync;
  logic             frame_end;

  axisv_timing_gen #(
    .H_PIXEL_COUNT (H_PIXEL_COUNT),
    .V_PIXEL_COUNT (V_PIXEL_COUNT),
    .H_FRONT       (H_FRONT),
    .H_SYNC        (H_SYNC),
    .H_BACK        (H_BACK),
    .V_FRONT       (V_FRONT),
    .V_SYNC        (V_SYNC),
    .V_BACK        (V_BACK)
  ) u_timing (
    .clk_i       (aclk_i),
    .rst_i       (rst_i),
    .h_cnt_o     (h_cnt),
    .v_cnt_o     (v_cnt),
    .active_o    (active),
    .hsync_o     (hsync),
    .vsync_o     (vsync),
    .frame_end_o (frame_end)
  );

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  de_q, de_d;
  logic                  hsync_q;
  logic                  vsync_q;
  logic                  locked_q;
  logic                  underflow_q, underflow_d;
  logic                  sync_err_q, sync_err_d;
  logic                  accept;
  logic                  tlast_exp;
  logic                  tuser_exp;

  assign s_axis_tready = !rst_i && ((state_q == ST_RESYNC) ||
                                    ((state_q == ST_RUN) && active));
  assign accept    = s_axis_tvalid && s_axis_tready;
  assign tlast_exp = (h_cnt == H_LAST_PIX);
  assign tuser_exp = tlast_exp && (v_cnt == V_LAST_PIX);

  always_comb begin
    state_d     = state_q;
    data_d      = '0;
    de_d        = 1'b0;
    underflow_d = 1'b0;
    sync_err_d  = 1'b0;
    case (state_q)
      ST_RESYNC: begin
        if (accept && s_axis_tuser) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (frame_end) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (active) begin
          de_d = 1'b1;
          if (accept) begin
            // A misframed pixel is still shown; only the lock is dropped.
            data_d = s_axis_tdata;
            if ((s_axis_tlast != tlast_exp) || (s_axis_tuser != tuser_exp)) begin
              sync_err_d = 1'b1;
              state_d    = ST_RESYNC;
            end
          end else begin
            underflow_d = 1'b1;
            state_d     = ST_RESYNC;
          end
        end
      end
      default: state_d = ST_RESYNC;
    endcase
  end

  always_ff @(posedge aclk_i) begin
    if (rst_i) begin
      state_q     <= ST_RESYNC;
      data_q      <= '0;
      de_q        <= 1'b0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      locked_q    <= 1'b0;
      underflow_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      de_q        <= de_d;
      hsync_q     <= hsync;
      vsync_q     <= vsync;
      locked_q    <= (state_q == ST_RUN);
      underflow_q <= underflow_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign lcd_data_o  = data_q;
  assign lcd_de_o    = de_q;
  assign lcd_hsync_o = hsync_q;
  assign lcd_vsync_o = vsync_q;
  assign locked_o    = locked_q;
  assign underflow_o = underflow_q;
  assign sync_err_o  = sync_err_q;

endmodule

// File: tb/tb_axisv_lcd_sink.sv
// Directed bench for axisv_lcd_sink with default 4x20 raster (8 x 23 = 184 clocks/frame).
module tb_axisv_lcd_sink;

  localparam int DW = 18;

  logic          aclk_i = 1'b0;
  logic          rst_i  = 1'b1;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic          s_axis_tuser;
  logic [DW-1:0] lcd_data_o;
  logic          lcd_de_o;
  logic          lcd_hsync_o;
  logic          lcd_vsync_o;
  logic          locked_o;
  logic          underflow_o;
  logic          sync_err_o;

  axisv_lcd_sink dut (
    .aclk_i        (aclk_i),
    .rst_i         (rst_i),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .lcd_data_o    (lcd_data_o),
    .lcd_de_o      (lcd_de_o),
    .lcd_hsync_o   (lcd_hsync_o),
    .lcd_vsync_o   (lcd_vsync_o),
    .locked_o      (locked_o),
    .underflow_o   (underflow_o),
    .sync_err_o    (sync_err_o)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk_i = ~aclk_i;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;   // clocks since the last reset edge
  logic src_en     = 1'b0;
  int src_x        = 0;
  int src_y        = 0;
  int drop_cyc     = -1;
  int err_cyc      = -1;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- source driver ----------------
  initial begin
    logic fire;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    forever begin
      @(negedge aclk_i);
      fire = s_axis_tvalid && s_axis_tready;
      @(posedge aclk_i);
      if (rst_i) cyc = 0;
      else cyc++;
      #1;
      if (fire) begin
        if (src_x == 3) begin
          src_x = 0;
          src_y = (src_y == 19) ? 0 : src_y + 1;
        end else begin
          src_x++;
        end
      end
      s_axis_tvalid = src_en && (cyc != drop_cyc);
      s_axis_tdata  = DW'(src_y);
      s_axis_tlast  = (src_x == 3) ^ (cyc == err_cyc);
      s_axis_tuser  = (src_x == 3) && (src_y == 19);
    end
  end

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc < n && guard < 5000) begin
      @(negedge aclk_i);
      guard++;
    end
    if (cyc < n) check("wait_cyc_timeout", 32'(cyc), 32'(n));
  endtask

  task automatic wait_locked(input string tag, input int exp_cyc);
    int got = -1;
    for (int i = 0; i < 600 && got < 0; i++) begin
      @(negedge aclk_i);
      if (locked_o) got = cyc;
    end
    check(tag, 32'(got), 32'(exp_cyc));
  endtask

  // ---------------- stimulus + checks ----------------
  initial begin
    int hs, vs, de_cnt, trdy_bad, lk_cnt, err_cnt, lk_low;
    logic [DW-1:0] exp;

    repeat (3) @(posedge aclk_i);
    @(negedge aclk_i);
    check("rst_outputs", 32'({lcd_data_o, lcd_de_o, lcd_hsync_o, lcd_vsync_o,
                              locked_o, underflow_o, sync_err_o}), 32'd0);
    check("rst_tready", 32'(s_axis_tready), 32'd0);
    rst_i = 1'b0;

    // Idle source: one full frame of timing in RESYNC.
    hs = 0; vs = 0; de_cnt = 0; trdy_bad = 0; lk_cnt = 0;
    for (int i = 1; i <= 184; i++) begin
      wait_cyc(i);
      hs += int'(lcd_hsync_o);
      vs += int'(lcd_vsync_o);
      de_cnt += int'(lcd_de_o);
      lk_cnt += int'(locked_o);
      if (s_axis_tready !== 1'b1) trdy_bad++;
    end
    check("idle_hsync_cycles", 32'(hs), 32'd46);
    check("idle_vsync_cycles", 32'(vs), 32'd8);
    check("idle_de_cycles", 32'(de_cnt), 32'd0);
    check("idle_locked_cycles", 32'(lk_cnt), 32'd0);
    check("idle_tready_low", 32'(trdy_bad), 32'd0);

    // Continuous correct frames: discard rest of frame in RESYNC, RUN from cycle 368.
    wait_cyc(199);
    src_en = 1'b1;
    wait_locked("first_lock_cycle", 369);
    for (int r = 0; r < 20; r++)
      for (int x = 0; x < 4; x++) exp_q.push_back(DW'(r));
    de_cnt = 0; err_cnt = 0; lk_low = 0;
    for (int c = 369; c <= 552; c++) begin
      wait_cyc(c);
      if (lcd_de_o) begin
        de_cnt++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check("run_pixel_row", 32'(lcd_data_o), 32'(exp));
      end else if (lcd_data_o != '0) begin
        check("run_data_idle_zero", 32'(lcd_data_o), 32'd0);
      end
      err_cnt += int'(underflow_o) + int'(sync_err_o);
      lk_low  += int'(!locked_o);
    end
    check("run_de_cycles", 32'(de_cnt), 32'd80);
    check("run_queue_left", 32'(exp_q.size()), 32'd0);
    check("run_err_pulses", 32'(err_cnt), 32'd0);
    check("run_locked_low", 32'(lk_low), 32'd0);

    // Early tlast at pixel (2,5) of the frame starting at cycle 552.
    err_cyc = 594;
    wait_cyc(594);
    check("serr_before", 32'(sync_err_o), 32'd0);
    wait_cyc(595);
    check("serr_pulse", 32'(sync_err_o), 32'd1);
    check("serr_pixel_de", 32'(lcd_de_o), 32'd1);
    check("serr_pixel_data", 32'(lcd_data_o), 32'd5);
    wait_cyc(596);
    check("serr_pulse_end", 32'(sync_err_o), 32'd0);
    check("serr_unlocked", 32'(locked_o), 32'd0);
    wait_cyc(600);
    check("serr_resync_tready", 32'(s_axis_tready), 32'd1);
    wait_cyc(700);
    check("serr_armed_tready", 32'(s_axis_tready), 32'd0);
    wait_locked("serr_relock_cycle", 737);

    // tvalid dropped at pixel (1,3) of the frame starting at cycle 736.
    drop_cyc = 761;
    wait_cyc(761);
    check("uf_before", 32'(underflow_o), 32'd0);
    check("uf_prev_pixel", 32'(lcd_data_o), 32'd3);
    wait_cyc(762);
    check("uf_pulse", 32'(underflow_o), 32'd1);
    check("uf_pixel_de", 32'(lcd_de_o), 32'd1);
    check("uf_pixel_zero", 32'(lcd_data_o), 32'd0);
    wait_cyc(763);
    check("uf_pulse_end", 32'(underflow_o), 32'd0);
    check("uf_unlocked", 32'(locked_o), 32'd0);
    wait_locked("uf_relock_cycle", 921);

    // Mid-line reset while in RUN.
    wait_cyc(930);
    check("pre_reset_locked", 32'(locked_o), 32'd1);
    rst_i  = 1'b1;
    src_en = 1'b0;
    #1;
    check("reset_tready", 32'(s_axis_tready), 32'd0);
    @(negedge aclk_i);
    check("midrst_outputs", 32'({lcd_data_o, lcd_de_o, lcd_hsync_o, lcd_vsync_o,
                                 locked_o, underflow_o, sync_err_o}), 32'd0);
    rst_i    = 1'b0;
    drop_cyc = -1;
    err_cyc  = -1;
    wait_cyc(1);
    check("post_reset_tready", 32'(s_axis_tready), 32'd1);
    check("post_reset_de", 32'(lcd_de_o), 32'd0);

    // Lone EOF beat accepted at h=7, v=22: ARMED for a whole frame, RUN at cycle 368.
    wait_cyc(182);
    src_x  = 3;
    src_y  = 19;
    src_en = 1'b1;
    wait_cyc(250);
    check("eof_armed_tready", 32'(s_axis_tready), 32'd0);
    wait_locked("eof_boundary_lock", 369);
    check("eof_first_pixel_de", 32'(lcd_de_o), 32'd1);
    check("eof_first_pixel_data", 32'(lcd_data_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
